// File: rtl/multdiv_if.sv
// Operand/result bundle between the execute stage and the iterative multiply/divide unit.
interface multdiv_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic             ctrl_MULT;
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) and divide (non-restoring), one bit per clock,
// fixed latency of WIDTH edges from the sampling edge to the result.
module multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic      clock,
   input logic      reset,
   multdiv_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int RW = WIDTH + 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   logic [CNT_W-1:0] cnt;
   logic             start, last, finish;
   logic             op_div, neg, div_zero, div_ovf;
   logic [WIDTH:0]   a_ext, b_ext, mag_a, mag_b;
   logic [PW-1:0]    mcand, acc, acc_next, prod;
   logic [WIDTH-1:0] mplier, quot, quot_next, quot_signed;
   logic [RW-1:0]    rem, rem_shift, rem_next, divisor;
   logic [WIDTH-1:0] result;
   logic             exception, mult_exc;

   assign start  = bus.ctrl_MULT | bus.ctrl_DIV;
   assign last   = (cnt == CNT_W'(WIDTH - 1));
   assign finish = (state == RUN) && last && !start;

   // Magnitudes are one bit wider so that the most negative operand stays representable.
   assign a_ext = {bus.data_operandA[WIDTH-1], bus.data_operandA};
   assign b_ext = {bus.data_operandB[WIDTH-1], bus.data_operandB};
   assign mag_a = a_ext[WIDTH] ? -a_ext : a_ext;
   assign mag_b = b_ext[WIDTH] ? -b_ext : b_ext;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: the default assignment first keeps this process free of inferred latches.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (!start && last) state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy           = (state == RUN);
      bus.data_resultRDY = (state == DONE);
   end

   assign bus.data_result    = result;
   assign bus.data_exception = exception;

   always_comb begin
      acc_next    = mplier[0] ? acc + mcand : acc;
      rem_shift   = {rem[RW-2:0], quot[WIDTH-1]};
      rem_next    = rem[RW-1] ? rem_shift + divisor : rem_shift - divisor;
      quot_next   = {quot[WIDTH-2:0], ~rem_next[RW-1]};
      prod        = neg ? -acc_next : acc_next;
      quot_signed = neg ? -quot_next : quot_next;
      mult_exc    = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
   end

   // NOTE: iteration registers are always reloaded by a start before they are read, so they carry no reset.
   always_ff @(posedge clock) begin
      if (start) begin
         op_div   <= !bus.ctrl_MULT;
         neg      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         div_zero <= (bus.data_operandB == '0);
         div_ovf  <= (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.data_operandB);
         mcand    <= PW'(mag_a);
         mplier   <= mag_b[WIDTH-1:0];
         acc      <= '0;
         rem      <= '0;
         quot     <= mag_a[WIDTH-1:0];
         divisor  <= RW'(mag_b);
      end else if (state == RUN) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         acc    <= acc_next;
         rem    <= rem_next;
         quot   <= quot_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt       <= '0;
         result    <= '0;
         exception <= 1'b0;
      end else begin
         if (start)              cnt <= '0;
         else if (state == RUN)  cnt <= cnt + CNT_W'(1);
         if (finish) begin
            if (!op_div) begin
               result    <= prod[WIDTH-1:0];
               exception <= mult_exc;
            end else if (div_zero) begin
               result    <= '0;
               exception <= 1'b1;
            end else begin
               result    <= quot_signed;
               exception <= div_ovf;
            end
         end
      end
   end
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: the driver pushes model results with their due cycle,
// a negedge monitor pops and compares on every RDY pulse and tracks the busy window.
module tb_multdiv_unit;
   localparam int WIDTH = 32;

   typedef struct packed {
      logic [31:0] res;
      logic        exc;
      logic [31:0] due;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   multdiv_if #(.WIDTH(WIDTH)) bus ();

   multdiv_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   bit          active = 1'b0;
   int          busy_from = 0;
   logic [31:0] last_res = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain signed arithmetic on the operand values.
   function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint p;
      int     sa, sb, lo;
      sa = a;
      sb = b;
      e.due = '0;
      if (!is_div) begin
         p = longint'(sa) * longint'(sb);
         lo = p[31:0];
         e.res = p[31:0];
         e.exc = (longint'(lo) != p);
      end else if (sb == 0) begin
         e.res = '0;
         e.exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b1;
      end else begin
         e.res = sa / sb;
         e.exc = 1'b0;
      end
      return e;
   endfunction

   always @(negedge clock) begin
      if (mon_en) begin
         check("busy", bus.busy, (active && cyc >= busy_from && cyc < busy_from + 32));
         if (bus.data_resultRDY) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rdy: got pulse, expected none pending (cycle %0d)", cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("rdy_cycle", cyc, mon_e.due);
               check("result", bus.data_result, mon_e.res);
               check("exception", bus.data_exception, mon_e.exc);
               last_res = mon_e.res;
            end
         end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL rdy: got 0, expected 1 (cycle %0d)", cyc);
            void'(exp_q.pop_front());
         end
      end
   end

   // Holds the ctrl line(s) across one edge; anything still pending is aborted by this start.
   task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      @(posedge clock);
      #1;
      bus.ctrl_MULT = 1'b0;
      bus.ctrl_DIV  = 1'b0;
      e = model(!m, a, b);
      e.due = cyc + 32;
      exp_q.delete();
      exp_q.push_back(e);
      active    = 1'b1;
      busy_from = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_done();
      int i = 0;
      while (exp_q.size() != 0 && i < 100) begin
         @(posedge clock);
         #1;
         i++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: got %0d results pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return 32'($urandom());
      endcase
   endfunction

   initial begin
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      idle(3);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_rdy", bus.data_resultRDY, 1'b0);
      check("reset_result", bus.data_result, 32'h0);
      check("reset_exception", bus.data_exception, 1'b0);
      reset  = 1'b0;
      mon_en = 1'b1;

      start_op(1, 0, 32'd7, 32'd6);                     wait_done();
      start_op(1, 0, -32'd3, 32'd5);                    wait_done();
      start_op(1, 0, 32'h0001_0000, 32'h0001_0000);     wait_done();
      start_op(0, 1, 32'd7, 32'd2);                     wait_done();
      start_op(0, 1, -32'd7, 32'd2);                    wait_done();
      start_op(0, 1, 32'd5, 32'd0);                     wait_done();
      start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);     wait_done();
      start_op(1, 1, 32'd100, 32'd7);                   wait_done();

      // Abort at E10: previous result must hold, only the divide completes.
      start_op(1, 0, 32'd12345, 32'd678);
      idle(9);
      check("hold_result", bus.data_result, last_res);
      start_op(0, 1, 32'd100, 32'd7);
      wait_done();

      // Second op sampled in the DONE cycle of the first.
      start_op(1, 0, 32'd9, 32'd9);
      idle(32);
      start_op(0, 1, -32'd100, 32'd3);
      wait_done();

      // Ctrl held high for three edges.
      start_op(1, 0, 32'd3, 32'd3);
      start_op(0, 1, 32'd50, 32'd5);
      start_op(1, 0, 32'hFFFF_0000, 32'd4);
      wait_done();

      // Reset at E15 of a multiply.
      start_op(1, 0, 32'd1000, 32'd1000);
      idle(14);
      reset = 1'b1;
      @(posedge clock);
      #1;
      exp_q.delete();
      active = 1'b0;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_rdy", bus.data_resultRDY, 1'b0);
      check("rst_result", bus.data_result, 32'h0);
      check("rst_exception", bus.data_exception, 1'b0);
      reset = 1'b0;
      idle(40);

      for (int k = 0; k < 60; k++) begin
         bit m;
         m = 1'($urandom_range(0, 1));
         start_op(m, !m, rand_opnd(), rand_opnd());
         if ($urandom_range(0, 4) == 0) begin
            idle($urandom_range(0, 31));
            m = 1'($urandom_range(0, 1));
            start_op(m, !m, rand_opnd(), rand_opnd());
         end
         wait_done();
         idle($urandom_range(0, 2));
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, expected finish before 1ms");
      $fatal(1);
   end
endmodule
